// File: rtl/rr_grant.sv
// Round-robin grant: one-hot grant and its index among the set request
// bits, searching upward from ptr and wrapping past the top channel.
module rr_grant #(
    parameter int REQ_WIDTH = 4,
    parameter int PW        = $clog2(REQ_WIDTH)
) (
    input  logic [REQ_WIDTH-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [REQ_WIDTH-1:0] grant,
    output logic [PW-1:0]        grant_idx,
    output logic                 grant_any
);

    localparam logic [PW:0] N_W = (PW+1)'(REQ_WIDTH);

    logic [2*REQ_WIDTH-1:0] dbl;
    logic [PW:0]            off;
    logic [PW:0]            sum;
    logic [PW:0]            wrapped;

    // Rotate the doubled request vector down by ptr so the first set bit
    // is the next requester at or above ptr; then map the offset back.
    always_comb begin
        dbl       = {req, req} >> ptr;
        grant_any = 1'b0;
        off       = '0;
        for (int unsigned j = 0; j < 2 * REQ_WIDTH; j++) begin
            if (!grant_any && dbl[j]) begin
                grant_any = 1'b1;
                off       = (PW+1)'(j);
            end
        end
        sum       = {1'b0, ptr} + off;
        wrapped   = (sum >= N_W) ? (sum - N_W) : sum;
        grant_idx = wrapped[PW-1:0];
        grant     = grant_any ? (REQ_WIDTH'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/arbiter.sv
// Round-robin N:1 valid/ready arbiter with a single output register stage.
module arbiter #(
    parameter int REQ_WIDTH = 4,
    parameter int DW        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQ_WIDTH-1:0]    valid_in,
    input  logic [REQ_WIDTH*DW-1:0] data_in,
    output logic [REQ_WIDTH-1:0]    ready_out,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic [DW-1:0]           data_out
);

    localparam int          PW  = $clog2(REQ_WIDTH);
    localparam logic [PW:0] N_W = (PW+1)'(REQ_WIDTH);

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_next;
    logic [REQ_WIDTH-1:0] grant;
    logic [PW-1:0]        grant_idx;
    logic                 grant_any;
    logic                 load_en;
    logic [PW:0]          idx_inc;
    logic [DW-1:0]        sel_data;

    rr_grant #(
        .REQ_WIDTH (REQ_WIDTH),
        .PW        (PW)
    ) u_rr_grant (
        .req       (valid_in),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Output register may load when empty or being drained this cycle;
    // accept is masked during reset so nothing appears taken.
    always_comb begin
        load_en   = !valid_out || ready_in;
        ready_out = grant & {REQ_WIDTH{load_en & rst}};
    end

    // Next pointer: one past the granted channel, wrapping to zero.
    always_comb begin
        idx_inc  = {1'b0, grant_idx} + (PW+1)'(1);
        if (idx_inc == N_W) begin
            idx_inc = '0;
        end
        ptr_next = idx_inc[PW-1:0];
    end

    // Data mux driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
            if (grant[i]) begin
                sel_data = data_in[i*DW +: DW];
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                valid_out <= 1'b1;
                data_out  <= sel_data;
                ptr       <= ptr_next;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for the round-robin arbiter.
module tb_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    ready_out;
    logic            ready_in;
    logic            valid_out;
    logic [DW-1:0]   data_out;

    int total = 0;
    int bad   = 0;

    // behavioural reference state
    logic          m_valid;
    logic [DW-1:0] m_data;
    int unsigned   m_ptr;

    logic [DW-1:0] q[$];
    int            wait_cnt[N];

    arbiter #(
        .REQ_WIDTH (N),
        .DW        (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // first requester at or above p, wrapping; -1 when none
    function automatic int model_pick(input logic [N-1:0] v, input int unsigned p);
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned c;
            c = (p + k) % N;
            if (v[c]) return int'(c);
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int c;
        if (!rst || (m_valid && !ready_in)) return '0;
        c = model_pick(valid_in, m_ptr);
        if (c < 0) return '0;
        return N'(1) << c;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ptr   = 0;
    endtask

    task automatic model_commit();
        int c;
        if (!rst) begin
            model_reset();
        end else if (!m_valid || ready_in) begin
            c = model_pick(valid_in, m_ptr);
            if (c >= 0) begin
                m_data  = data_in[c*DW +: DW];
                m_valid = 1'b1;
                m_ptr   = (c + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = '0;
        ready_in = 1'b0;
        data_in  = 32'h87654321;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        valid_in = '1;
        ready_in = 1'b1;
        data_in  = 32'h87654321;
        model_reset();
        #2;
        total++;
        if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h r=%b want v=0 d=00 r=0000", valid_out, data_out, ready_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (valid_out !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_held: got v=%b d=%h want v=0 d=00", valid_out, data_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_d[5];
        logic [N-1:0]  exp_r[5];
        exp_d = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h21};
        exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        valid_in = '1;
        ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            total++;
            if (ready_out !== exp_r[k]) begin
                bad++;
                $display("FAIL stream_ready[%0d]: got %b want %b", k, ready_out, exp_r[k]);
            end
            step();
            total++;
            if (valid_out !== 1'b1 || data_out !== exp_d[k]) begin
                bad++;
                $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h", k, valid_out, data_out, exp_d[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp_d[4];
        exp_d = '{8'h21, 8'h43, 8'h65, 8'h87};
        do_reset();
        valid_in = '1;
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) step();
        ready_in = 1'b0;
        #2;
        total++;
        if (ready_out !== 4'b0000) begin
            bad++;
            $display("FAIL stall_ready: got %b want 0000", ready_out);
        end
        step();
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'h87) begin
            bad++;
            $display("FAIL stall_hold: got v=%b d=%h want v=1 d=87", valid_out, data_out);
        end
        ready_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            total++;
            if (ready_out !== (N'(1) << k)) begin
                bad++;
                $display("FAIL stall_resume_ready[%0d]: got %b want %b", k, ready_out, N'(1) << k);
            end
            step();
            total++;
            if (data_out !== exp_d[k]) begin
                bad++;
                $display("FAIL stall_resume_data[%0d]: got %h want %h", k, data_out, exp_d[k]);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset();
        valid_in = 4'b0101;
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            total++;
            if (ready_out !== ((k % 2 == 0) ? 4'b0001 : 4'b0100)) begin
                bad++;
                $display("FAIL alt_ready[%0d]: got %b want %b", k, ready_out, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            end
            step();
            total++;
            if (data_out !== ((k % 2 == 0) ? 8'h21 : 8'h65)) begin
                bad++;
                $display("FAIL alt_data[%0d]: got %h want %h", k, data_out, (k % 2 == 0) ? 8'h21 : 8'h65);
            end
        end
    endtask

    task automatic test_idle();
        do_reset();
        valid_in = '1;
        ready_in = 1'b1;
        step();
        step();
        valid_in = '0;
        for (int k = 0; k < 2; k++) begin
            #2;
            total++;
            if (ready_out !== 4'b0000) begin
                bad++;
                $display("FAIL idle_ready[%0d]: got %b want 0000", k, ready_out);
            end
            step();
            total++;
            if (valid_out !== 1'b0 || data_out !== 8'h43) begin
                bad++;
                $display("FAIL idle_out[%0d]: got v=%b d=%h want v=0 d=43", k, valid_out, data_out);
            end
        end
        valid_in = '1;
        #2;
        total++;
        if (ready_out !== 4'b0100) begin
            bad++;
            $display("FAIL idle_ptr_kept: got %b want 0100", ready_out);
        end
        step();
    endtask

    task automatic test_single();
        do_reset();
        valid_in = 4'b1000;
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            total++;
            if (ready_out !== 4'b1000) begin
                bad++;
                $display("FAIL single_ready[%0d]: got %b want 1000", k, ready_out);
            end
            step();
            total++;
            if (valid_out !== 1'b1 || data_out !== 8'h87) begin
                bad++;
                $display("FAIL single_data[%0d]: got v=%b d=%h want v=1 d=87", k, valid_out, data_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid_in = '1;
        ready_in = 1'b1;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b0;
        #1;
        total++;
        if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_async: got v=%b d=%h r=%b want v=0 d=00 r=0000", valid_out, data_out, ready_out);
        end
        model_reset();
        step();
        rst = 1'b1;
        #2;
        total++;
        if (ready_out !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_first_ready: got %b want 0001", ready_out);
        end
        step();
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'h21) begin
            bad++;
            $display("FAIL reset_mid_first_beat: got v=%b d=%h want v=1 d=21", valid_out, data_out);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        int           g;
        do_reset();
        q.delete();
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            valid_in = N'($urandom_range(0, (1 << N) - 1));
            data_in  = $urandom;
            ready_in = ($urandom_range(0, 9) < 7);
            #2;
            exp_r = model_ready();
            total++;
            if (ready_out !== exp_r) begin
                bad++;
                $display("FAIL rand_ready@%0d: got %b want %b", cyc, ready_out, exp_r);
            end
            total++;
            if ($countones(ready_out) > 1) begin
                bad++;
                $display("FAIL rand_onehot@%0d: got %b want at most one bit", cyc, ready_out);
            end
            if (valid_out && ready_in) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_order@%0d: got beat %h want none pending", cyc, data_out);
                end else if (data_out !== q.pop_front()) begin
                    bad++;
                    $display("FAIL rand_order@%0d: got %h want earlier accepted beat", cyc, data_out);
                end
            end
            g = -1;
            for (int i = 0; i < N; i++) if (ready_out[i]) g = i;
            if (g >= 0) begin
                q.push_back(data_in[g*DW +: DW]);
                for (int i = 0; i < N; i++) begin
                    if (i == g || !valid_in[i]) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        total++;
                        if (wait_cnt[i] > N - 1) begin
                            bad++;
                            $display("FAIL rand_starve@%0d: ch%0d waited %0d grants want <= %0d", cyc, i, wait_cnt[i], N - 1);
                        end
                    end
                end
            end else begin
                for (int i = 0; i < N; i++) if (!valid_in[i]) wait_cnt[i] = 0;
            end
            step();
            total++;
            if (valid_out !== m_valid || (m_valid && data_out !== m_data)) begin
                bad++;
                $display("FAIL rand_out@%0d: got v=%b d=%h want v=%b d=%h", cyc, valid_out, data_out, m_valid, m_data);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        valid_in = '0;
        data_in  = '0;
        ready_in = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_alternate();
        test_idle();
        test_single();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameter REQ_WIDTH, default 4, sets the number of requesting channels (>=2).
REQ-002 Parameter DW, default 8, sets the data width per channel in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  REQ_WIDTH  per-channel request; bit i means channel i presents data.
REQ-006 data_in  input  REQ_WIDTH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
REQ-007 ready_out  output  REQ_WIDTH  per-channel accept; bit i high means channel i transfers this cycle.
REQ-008 ready_in  input  1  downstream ready for the output beat.
REQ-009 valid_out  output  1  output register holds a valid beat.
REQ-010 data_out  output  DW  beat payload from the output register.

Function
REQ-011 The block SHALL be a round-robin N:1 arbiter with valid/ready handshakes and one output register stage.
REQ-012 load_en SHALL be high when valid_out==0 or ready_in==1 (register empty or draining this cycle).
REQ-013 Grant SHALL be one-hot among set valid_in bits: first requester at or above pointer ptr, wrapping from REQ_WIDTH-1 to 0.
REQ-014 ready_out SHALL equal grant & {REQ_WIDTH{load_en}}; at most one bit set; all zero when valid_in==0 or load_en==0.
REQ-015 ready_out SHALL be combinational from valid_in, ptr, valid_out, ready_in (no dependence on data_in).
REQ-016 On a clock edge with load_en and any valid_in set: data_out <= granted channel's slice, valid_out <= 1, ptr <= (granted index + 1) mod REQ_WIDTH.
REQ-017 On a clock edge with load_en and valid_in==0: valid_out <= 0, data_out and ptr unchanged.
REQ-018 With valid_out==1 and ready_in==0: data_out, valid_out, ptr SHALL hold; ready_out SHALL be 0.
REQ-019 Latency SHALL be exactly one cycle from input handshake to valid_out; full throughput of one beat per cycle when ready_in stays high.
REQ-020 A channel whose valid_in drops before being granted SHALL simply be skipped; no state records pending requests.
REQ-021 With a single active requester, it SHALL be granted every load cycle.

Reset
REQ-022 While rst==0: valid_out=0, data_out=0, ptr=0 (channel 0 highest priority), ready_out=0, asynchronously.
REQ-023 Reset mid-transfer SHALL discard the held beat; first grant after release SHALL start from channel 0.
REQ-024 Deassertion SHALL take effect on the next rising clk edge; no other registers exist.

Structure
REQ-025 No shared package is needed; REQ_WIDTH and DW are the only constants, and the pointer width SHALL be $clog2(REQ_WIDTH).
REQ-026 One sub-module, rr_grant, SHALL compute the one-hot grant and granted index from request vector and ptr (double-width masked priority encoder); arbiter holds ptr, output register and data mux.

Verification
REQ-027 REQ_WIDTH=4, DW=8, valid_in=4'b1111, data_in=32'h87654321, ready_in=1 after reset -> data_out 8'h21,8'h43,8'h65,8'h87,8'h21... on consecutive cycles, valid_out=1, ready_out 0001,0010,0100,1000 rotating.
REQ-028 Same stimulus, ready_in=0 for one cycle after 4 beats -> data_out held, ready_out=0000, next beat resumes at the correct channel with no loss or duplicate.
REQ-029 valid_in=4'b0101 -> grants alternate channel 0 and 2; data_out alternates 8'h21, 8'h65.
REQ-030 valid_in=4'b0000 with ready_in=1 -> valid_out falls to 0 one cycle later; ready_out=0000.
REQ-031 rst pulsed low during streaming -> valid_out=0 and data_out=0 immediately; after release first beat is 8'h21 (channel 0).
REQ-032 Random valid_in/ready_in for 1000 cycles -> ready_out always one-hot or zero; every accepted beat appears once in order; no requester starved beyond REQ_WIDTH-1 grants.
